alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/cpu_opcodes_pkg.sv | 34 +++
 rtl/alu_sequencer_if.sv | 28 ++
 rtl/four_bit_alu.sv | 32 +++
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_opcodes_pkg.sv
// Shared opcode/state/register-select types for the ALU sequencer and its ALU.
// Opcodes 16..31 are encodable on the bus but illegal.
package cpu_opcodes;

    typedef enum logic [4:0] {
        AND_A_B = 5'd0,  OR_A_B = 5'd1,  XOR_A_B = 5'd2,  ADD_A_B = 5'd3,
        INC_A   = 5'd4,  INC_B  = 5'd5,  INC_C   = 5'd6,
        DEC_A   = 5'd7,  DEC_B  = 5'd8,  DEC_C   = 5'd9,
        SHL_A   = 5'd10, SHL_B  = 5'd11, SHL_C   = 5'd12,
        TST_A   = 5'd13, TST_B  = 5'd14, TST_C   = 5'd15
    } alu_opcode_t;

    typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} seq_state_t;

    typedef enum logic [1:0] {SEL_A, SEL_B, SEL_C, SEL_NONE} reg_sel_t;

    function automatic logic op_legal(alu_opcode_t op);
        return op <= TST_C;
    endfunction

    // Register feeding operand a; also the writeback target for non-TST ops.
    function automatic reg_sel_t op_reg(alu_opcode_t op);
        case (op)
            INC_B, DEC_B, SHL_B, TST_B: return SEL_B;
            INC_C, DEC_C, SHL_C, TST_C: return SEL_C;
            default:                    return SEL_A;
        endcase
    endfunction

    function automatic logic op_writes(alu_opcode_t op);
        return !(op inside {TST_A, TST_B, TST_C});
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle between a command master and the ALU sequencer.
interface alu_seq_if #(parameter int DATA_W = 4);
    import cpu_opcodes::*;

    logic              cmd_valid;
    logic              cmd_ready;
    alu_opcode_t       cmd_op;
    logic              cmd_load;
    logic [1:0]        cmd_dst;
    logic [DATA_W-1:0] cmd_imm;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_r;
    logic              rsp_zf;
    logic              rsp_cf;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_load, cmd_dst, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_r, rsp_zf, rsp_cf, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_load, cmd_dst, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_r, rsp_zf, rsp_cf, rsp_err
    );

endinterface

// File: rtl/four_bit_alu.sv
// Combinational ALU: logic ops, add, inc, dec (cf = borrow), shift-left (cf = msb out), test.
module four_bit_alu
    import cpu_opcodes::*;
#(
    parameter int DATA_W = 4
) (
    input  alu_opcode_t       op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] r,
    output logic              zf,
    output logic              cf
);

    always_comb begin
        r  = '0;
        cf = 1'b0;
        case (op)
            AND_A_B:             r = a & b;
            OR_A_B:              r = a | b;
            XOR_A_B:             r = a ^ b;
            ADD_A_B:             {cf, r} = {1'b0, a} + {1'b0, b};
            INC_A, INC_B, INC_C: {cf, r} = {1'b0, a} + (DATA_W+1)'(1);
            DEC_A, DEC_B, DEC_C: {cf, r} = {1'b0, a} - (DATA_W+1)'(1);
            SHL_A, SHL_B, SHL_C: {cf, r} = {a, 1'b0};
            TST_A, TST_B, TST_C: r = a;
            default:             r = '0;
        endcase
        zf = (r == '0);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state (IDLE/EXEC/WB/RESP) sequencer driving one ALU over registers A/B/C.
// Optional load-immediate path enabled by defining ALU_SEQ_LOADI_EN.
module alu_sequencer
    import cpu_opcodes::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_seq_if.slave          bus,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [DATA_W-1:0] reg_c,
    output logic              busy
);

    seq_state_t        state_q;
    alu_opcode_t       op_q;
    reg_sel_t          dst_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              err_q;
    logic [DATA_W-1:0] alu_r_q;
    logic              alu_zf_q, alu_cf_q;
    logic [DATA_W-1:0] ra, rb, rc;
    logic              zf_q, cf_q;
    logic [DATA_W-1:0] rsp_r_q;
    logic              rsp_err_q, rsp_valid_q;

    alu_opcode_t       op_rt;
    reg_sel_t          sel_rt, dst_rt;
    logic [DATA_W-1:0] a_rt;
    logic              err_rt;

    logic [DATA_W-1:0] alu_r;
    logic              alu_zf, alu_cf;

    // Operand routing and legality, evaluated on the command as presented.
    always_comb begin
        sel_rt = op_reg(bus.cmd_op);
        case (sel_rt)
            SEL_B:   a_rt = rb;
            SEL_C:   a_rt = rc;
            default: a_rt = ra;
        endcase
        op_rt  = bus.cmd_op;
        dst_rt = op_writes(bus.cmd_op) ? sel_rt : SEL_NONE;
        err_rt = !op_legal(bus.cmd_op);
`ifdef ALU_SEQ_LOADI_EN
        if (bus.cmd_load) begin
            op_rt  = TST_A;
            a_rt   = bus.cmd_imm;
            dst_rt = reg_sel_t'(bus.cmd_dst);
            err_rt = err_rt | (bus.cmd_dst == 2'd3);
        end
`endif
    end

`ifndef ALU_SEQ_LOADI_EN
    logic unused_load;
    assign unused_load = ^{bus.cmd_load, bus.cmd_dst, bus.cmd_imm};
`endif

    four_bit_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .r  (alu_r),
        .zf (alu_zf),
        .cf (alu_cf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= AND_A_B;
            dst_q       <= SEL_NONE;
            a_q         <= '0;
            b_q         <= '0;
            err_q       <= 1'b0;
            alu_r_q     <= '0;
            alu_zf_q    <= 1'b0;
            alu_cf_q    <= 1'b0;
            ra          <= '0;
            rb          <= '0;
            rc          <= '0;
            zf_q        <= 1'b0;
            cf_q        <= 1'b0;
            rsp_r_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    op_q    <= op_rt;
                    dst_q   <= dst_rt;
                    a_q     <= a_rt;
                    b_q     <= rb;
                    err_q   <= err_rt;
                    state_q <= EXEC;
                end
                EXEC: begin
                    alu_r_q  <= alu_r;
                    alu_zf_q <= alu_zf;
                    alu_cf_q <= alu_cf;
                    state_q  <= WB;
                end
                WB: begin
                    // Illegal commands respond with r=0 and leave state untouched.
                    if (err_q) begin
                        rsp_r_q <= '0;
                    end else begin
                        rsp_r_q <= alu_r_q;
                        zf_q    <= alu_zf_q;
                        cf_q    <= alu_cf_q;
                        case (dst_q)
                            SEL_A:   ra <= alu_r_q;
                            SEL_B:   rb <= alu_r_q;
                            SEL_C:   rc <= alu_r_q;
                            default: ;
                        endcase
                    end
                    rsp_err_q   <= err_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so ready is low during reset and high the cycle after release.
    assign bus.cmd_ready = rst_n && (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_r     = rsp_r_q;
    assign bus.rsp_zf    = zf_q;
    assign bus.rsp_cf    = cf_q;
    assign bus.rsp_err   = rsp_err_q;
    assign reg_a         = ra;
    assign reg_b         = rb;
    assign reg_c         = rc;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random commands
// checked against an arithmetic reference model of the register file and flags.
module tb_alu_sequencer;
    import cpu_opcodes::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] reg_a, reg_b, reg_c;
    logic busy;
    int vectors = 0;
    int miscompares = 0;

    int m_reg [3];
    bit m_zf, m_cf;

    alu_seq_if #(.DATA_W(4)) bus ();

    alu_sequencer #(.DATA_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .reg_a (reg_a),
        .reg_b (reg_b),
        .reg_c (reg_c),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_reg[i] = 0;
        m_zf = 0;
        m_cf = 0;
    endtask

    // Reference behaviour written from the rules: modulo-16 arithmetic on integers.
    task automatic model_exec(input alu_opcode_t op, input logic ld, input logic [1:0] dst,
                              input logic [3:0] imm, output logic [3:0] er,
                              output logic ezf, output logic ecf, output logic eerr);
        int res, a, idx, wb;
        bit c;
        eerr = (int'(op) > 15);
`ifdef ALU_SEQ_LOADI_EN
        if (ld && dst == 2'd3) eerr = 1'b1;
`endif
        if (eerr) begin
            er = 4'd0; ezf = m_zf; ecf = m_cf;
            return;
        end
        res = 0; c = 0; wb = -1;
`ifdef ALU_SEQ_LOADI_EN
        if (ld) begin
            res = int'(imm); wb = int'(dst);
        end else
`endif
        begin
            if (op inside {INC_B, DEC_B, SHL_B, TST_B}) idx = 1;
            else if (op inside {INC_C, DEC_C, SHL_C, TST_C}) idx = 2;
            else idx = 0;
            a = m_reg[idx];
            wb = idx;
            case (op)
                AND_A_B: res = m_reg[0] & m_reg[1];
                OR_A_B:  res = m_reg[0] | m_reg[1];
                XOR_A_B: res = m_reg[0] ^ m_reg[1];
                ADD_A_B: begin res = m_reg[0] + m_reg[1]; c = res > 15; end
                INC_A, INC_B, INC_C: begin res = a + 1; c = res > 15; end
                DEC_A, DEC_B, DEC_C: begin res = a + 15; c = (a == 0); end
                SHL_A, SHL_B, SHL_C: begin res = a * 2; c = res > 15; end
                default: begin res = a; wb = -1; end
            endcase
            res = res % 16;
        end
        if (wb >= 0) m_reg[wb] = res;
        m_zf = (res == 0);
        m_cf = c;
        er = 4'(res); ezf = m_zf; ecf = m_cf;
    endtask

    // Issue one command, wait for its response, hold rsp_ready low for 'hold' cycles.
    task automatic do_cmd(input alu_opcode_t op, input logic ld, input logic [1:0] dst,
                          input logic [3:0] imm, input int hold,
                          output logic [3:0] r, output logic zf, output logic cf,
                          output logic err, output int lat, output bit tmo);
        int n;
        tmo = 0; lat = 0; r = '0; zf = 0; cf = 0; err = 0;
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_load = ld; bus.cmd_dst = dst; bus.cmd_imm = imm;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.cmd_ready) begin bus.cmd_valid = 1'b0; tmo = 1; return; end
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 12);
        if (!bus.rsp_valid) begin tmo = 1; return; end
        r = bus.rsp_r; zf = bus.rsp_zf; cf = bus.rsp_cf; err = bus.rsp_err;
        repeat (hold) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk); rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_r, bus.rsp_zf, bus.rsp_cf, bus.rsp_err,
             reg_a, reg_b, reg_c, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b rvalid=%b r=%h zf=%b cf=%b err=%b a=%h b=%h c=%h busy=%b, all required 0",
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_r, bus.rsp_zf, bus.rsp_cf, bus.rsp_err,
                     reg_a, reg_b, reg_c, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL ready_after_release: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_inc_a();
        logic [3:0] r; logic zf, cf, err, er, ez, ec; logic [3:0] erv; int lat; bit tmo;
        pulse_reset();
        model_exec(INC_A, 0, 0, 0, erv, ez, ec, er);
        do_cmd(INC_A, 0, 0, 0, 0, r, zf, cf, err, lat, tmo);
        vectors++;
        if (tmo || {r, zf, cf, err} !== {4'h1, 1'b0, 1'b0, 1'b0} || reg_a !== 4'h1) begin
            miscompares++;
            $display("FAIL inc_a: tmo=%b r=%h zf=%b cf=%b err=%b a=%h, want r=1 zf=0 cf=0 err=0 a=1",
                     tmo, r, zf, cf, err, reg_a);
        end
        vectors++;
        if (lat !== 3) begin
            miscompares++; $display("FAIL inc_a_latency: rsp_valid at negedge %0d after accept, want 3", lat);
        end
    endtask

    task automatic test_dec_c();
        logic [3:0] r, erv; logic zf, cf, err, ez, ec, ee; int lat; bit tmo;
        pulse_reset();
        model_exec(DEC_C, 0, 0, 0, erv, ez, ec, ee);
        do_cmd(DEC_C, 0, 0, 0, 1, r, zf, cf, err, lat, tmo);
        vectors++;
        if (tmo || {r, zf, cf, err} !== {4'hF, 1'b0, 1'b1, 1'b0} || reg_c !== 4'hF) begin
            miscompares++;
            $display("FAIL dec_c: tmo=%b r=%h zf=%b cf=%b c=%h, want r=f zf=0 cf=1 c=f", tmo, r, zf, cf, reg_c);
        end
    endtask

    task automatic test_add_wrap();
        logic [3:0] r, erv; logic zf, cf, err, ez, ec, ee; int lat; bit tmo;
        pulse_reset();
`ifdef ALU_SEQ_LOADI_EN
        model_exec(TST_A, 1, 2'd0, 4'hF, erv, ez, ec, ee);
        do_cmd(TST_A, 1, 2'd0, 4'hF, 0, r, zf, cf, err, lat, tmo);
        vectors++;
        if (tmo || {r, zf, cf} !== {4'hF, 1'b0, 1'b0} || reg_a !== 4'hF) begin
            miscompares++; $display("FAIL loadi_a: r=%h zf=%b cf=%b a=%h, want f 0 0 f", r, zf, cf, reg_a);
        end
        model_exec(TST_A, 1, 2'd1, 4'h1, erv, ez, ec, ee);
        do_cmd(TST_A, 1, 2'd1, 4'h1, 0, r, zf, cf, err, lat, tmo);
`else
        model_exec(DEC_A, 0, 0, 0, erv, ez, ec, ee);
        do_cmd(DEC_A, 1, 2'd2, 4'h7, 0, r, zf, cf, err, lat, tmo);
        model_exec(INC_B, 0, 0, 0, erv, ez, ec, ee);
        do_cmd(INC_B, 1, 2'd0, 4'h3, 0, r, zf, cf, err, lat, tmo);
`endif
        vectors++;
        if (reg_a !== 4'hF || reg_b !== 4'h1) begin
            miscompares++; $display("FAIL add_setup: a=%h b=%h, want a=f b=1", reg_a, reg_b);
        end
        model_exec(ADD_A_B, 0, 0, 0, erv, ez, ec, ee);
        do_cmd(ADD_A_B, 0, 0, 0, 2, r, zf, cf, err, lat, tmo);
        vectors++;
        if (tmo || {r, zf, cf, err} !== {4'h0, 1'b1, 1'b1, 1'b0} || reg_a !== 4'h0 || reg_b !== 4'h1) begin
            miscompares++;
            $display("FAIL add_wrap: r=%h zf=%b cf=%b err=%b a=%h b=%h, want r=0 zf=1 cf=1 err=0 a=0 b=1",
                     r, zf, cf, err, reg_a, reg_b);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] r, erv; logic zf, cf, err, ez, ec, ee; int lat; bit tmo;
        logic [11:0] regs0; bit zf0, cf0;
        alu_opcode_t bad;
        regs0 = {reg_a, reg_b, reg_c}; zf0 = m_zf; cf0 = m_cf;
        bad = alu_opcode_t'(5'(16 + $urandom_range(0, 15)));
        model_exec(bad, 0, 0, 0, erv, ez, ec, ee);
        do_cmd(bad, 0, 0, 0, 0, r, zf, cf, err, lat, tmo);
        vectors++;
        if (tmo || err !== 1'b1 || r !== 4'h0 || zf !== zf0 || cf !== cf0 || {reg_a, reg_b, reg_c} !== regs0) begin
            miscompares++;
            $display("FAIL illegal_op: op=%0d err=%b r=%h zf=%b cf=%b regs=%h, want err=1 r=0 zf=%b cf=%b regs=%h",
                     int'(bad), err, r, zf, cf, {reg_a, reg_b, reg_c}, zf0, cf0, regs0);
        end
`ifdef ALU_SEQ_LOADI_EN
        model_exec(TST_A, 1, 2'd3, 4'h5, erv, ez, ec, ee);
        do_cmd(TST_A, 1, 2'd3, 4'h5, 0, r, zf, cf, err, lat, tmo);
        vectors++;
        if (err !== 1'b1 || r !== 4'h0 || {reg_a, reg_b, reg_c} !== regs0) begin
            miscompares++; $display("FAIL illegal_dst: err=%b r=%h regs=%h, want 1 0 %h", err, r, {reg_a, reg_b, reg_c}, regs0);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [3:0] e1r, e2r, r0; logic e1z, e1c, e1e, e2z, e2c, e2e, z0, c0, x0;
        int n; bit stable, idle_ok;
        model_exec(INC_B, 0, 0, 0, e1r, e1z, e1c, e1e);
        model_exec(DEC_A, 0, 0, 0, e2r, e2z, e2c, e2e);
        @(negedge clk);
        bus.cmd_op = INC_B; bus.cmd_load = 0; bus.cmd_dst = 0; bus.cmd_imm = 0; bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.cmd_op = DEC_A;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 12);
        r0 = bus.rsp_r; z0 = bus.rsp_zf; c0 = bus.rsp_cf; x0 = bus.rsp_err;
        vectors++;
        if (!bus.rsp_valid || {r0, z0, c0, x0} !== {e1r, e1z, e1c, e1e}) begin
            miscompares++;
            $display("FAIL bp_first: valid=%b r=%h zf=%b cf=%b err=%b, want r=%h zf=%b cf=%b err=%b",
                     bus.rsp_valid, r0, z0, c0, x0, e1r, e1z, e1c, e1e);
        end
        stable = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({bus.rsp_valid, bus.rsp_r, bus.rsp_zf, bus.rsp_cf, bus.rsp_err, bus.cmd_ready} !==
                {1'b1, r0, z0, c0, x0, 1'b0}) stable = 0;
        end
        vectors++;
        if (!stable) begin miscompares++; $display("FAIL bp_stable: rsp changed or cmd_ready high while stalled, want stable"); end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_after_hs: rsp_valid=%b cmd_ready=%b, want 0 1", bus.rsp_valid, bus.cmd_ready);
        end
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 12);
        vectors++;
        if (!bus.rsp_valid || {bus.rsp_r, bus.rsp_zf, bus.rsp_cf, bus.rsp_err} !== {e2r, e2z, e2c, e2e}) begin
            miscompares++;
            $display("FAIL bp_second: valid=%b r=%h zf=%b cf=%b, want r=%h zf=%b cf=%b",
                     bus.rsp_valid, bus.rsp_r, bus.rsp_zf, bus.rsp_cf, e2r, e2z, e2c);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        idle_ok = 1;
        repeat (6) begin @(negedge clk); if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) idle_ok = 0; end
        vectors++;
        if (!idle_ok || reg_a !== 4'(m_reg[0]) || reg_b !== 4'(m_reg[1])) begin
            miscompares++;
            $display("FAIL bp_once: idle_ok=%b a=%h b=%h, want idle a=%h b=%h", idle_ok, reg_a, reg_b,
                     4'(m_reg[0]), 4'(m_reg[1]));
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] r, erv; logic zf, cf, err, ez, ec, ee; int lat, n; bit tmo, quiet;
        pulse_reset();
        repeat (9) begin
            model_exec(INC_B, 0, 0, 0, erv, ez, ec, ee);
            do_cmd(INC_B, 0, 0, 0, 0, r, zf, cf, err, lat, tmo);
        end
        vectors++;
        if (reg_b !== 4'h9) begin miscompares++; $display("FAIL rm_setup: b=%h want 9", reg_b); end
        @(negedge clk);
        bus.cmd_op = SHL_B; bus.cmd_load = 0; bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_r, bus.rsp_zf, bus.rsp_cf, bus.rsp_err,
             reg_a, reg_b, reg_c, busy} !== '0) begin
            miscompares++;
            $display("FAIL rm_outputs: rvalid=%b r=%h zf=%b cf=%b a=%h b=%h c=%h busy=%b, all required 0",
                     bus.rsp_valid, bus.rsp_r, bus.rsp_zf, bus.rsp_cf, reg_a, reg_b, reg_c, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        quiet = 1;
        repeat (4) begin @(negedge clk); if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 0; end
        vectors++;
        if (!quiet) begin miscompares++; $display("FAIL rm_no_rsp: response or busy seen after reset, want none"); end
        model_exec(TST_B, 0, 0, 0, erv, ez, ec, ee);
        do_cmd(TST_B, 0, 0, 0, 0, r, zf, cf, err, lat, tmo);
        vectors++;
        if (tmo || {r, zf, cf, err} !== {4'h0, 1'b1, 1'b0, 1'b0} || reg_b !== 4'h0) begin
            miscompares++;
            $display("FAIL rm_tst_b: r=%h zf=%b cf=%b b=%h, want r=0 zf=1 cf=0 b=0", r, zf, cf, reg_b);
        end
    endtask

    task automatic test_back_to_back();
        int acc, last, gap_bad; logic [3:0] erv; logic ez, ec, ee; int n;
        @(negedge clk);
        bus.cmd_op = INC_A; bus.cmd_load = 0; bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
        acc = 0; last = -1; gap_bad = 0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.cmd_ready) begin
                if (last >= 0 && i - last != 4) gap_bad++;
                last = i; acc++;
                model_exec(INC_A, 0, 0, 0, erv, ez, ec, ee);
            end
        end
        @(negedge clk); bus.cmd_valid = 1'b0;
        n = 0;
        while (busy && n < 10) begin @(negedge clk); n++; end
        bus.rsp_ready = 1'b0;
        vectors++;
        if (gap_bad != 0 || acc != 6) begin
            miscompares++; $display("FAIL b2b_interval: accepts=%0d bad_gaps=%0d, want 6 accepts 4 apart", acc, gap_bad);
        end
        vectors++;
        if (reg_a !== 4'(m_reg[0]) || busy !== 1'b0) begin
            miscompares++; $display("FAIL b2b_result: a=%h busy=%b, want a=%h busy=0", reg_a, busy, 4'(m_reg[0]));
        end
    endtask

    task automatic test_random();
        logic [3:0] r, erv, imm; logic zf, cf, err, ez, ec, ee, ld; logic [1:0] dst;
        int lat; bit tmo; alu_opcode_t op;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) op = alu_opcode_t'(5'(16 + $urandom_range(0, 15)));
            else op = alu_opcode_t'(5'($urandom_range(0, 15)));
            ld = 1'($urandom_range(0, 1)); dst = 2'($urandom_range(0, 3)); imm = 4'($urandom_range(0, 15));
            model_exec(op, ld, dst, imm, erv, ez, ec, ee);
            do_cmd(op, ld, dst, imm, $urandom_range(0, 3), r, zf, cf, err, lat, tmo);
            vectors++;
            if (tmo || lat != 3 || {r, zf, cf, err} !== {erv, ez, ec, ee} ||
                {reg_a, reg_b, reg_c} !== {4'(m_reg[0]), 4'(m_reg[1]), 4'(m_reg[2])}) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d ld=%b dst=%0d imm=%h: tmo=%b lat=%0d r=%h zf=%b cf=%b err=%b regs=%h, want lat=3 r=%h zf=%b cf=%b err=%b regs=%h",
                         i, int'(op), ld, dst, imm, tmo, lat, r, zf, cf, err, {reg_a, reg_b, reg_c},
                         erv, ez, ec, ee, {4'(m_reg[0]), 4'(m_reg[1]), 4'(m_reg[2])});
            end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = AND_A_B; bus.cmd_load = 1'b0;
        bus.cmd_dst = 2'd0; bus.cmd_imm = 4'd0; bus.rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_inc_a();
        test_dec_c();
        test_add_wrap();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
